// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared constants for the jt6295 ADPCM voice pipeline
package jt6295_pkg;
   localparam int VOICES         = 4;
   localparam int DEFAULT_WIDTH  = 12;
   localparam int DEFAULT_STAGES = VOICES;
endpackage

// File: rtl/jt6295_shift_lane.sv
// jt6295_shift_lane: 1-bit clock-enabled shift chain with async reset
module jt6295_shift_lane #(
   parameter int STAGES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clk_en,
   input  logic din,
   output logic drop
);
   logic [STAGES-1:0] chain_q, chain_d;
   always_comb begin
      chain_d[0] = din;
      for (int i = 1; i < STAGES; i++) chain_d[i] = chain_q[i-1];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) chain_q <= '0;
      else if (clk_en) chain_q <= chain_d;
   assign drop = chain_q[STAGES-1];
endmodule

// File: rtl/jt6295_shift_rst.sv
// jt6295_shift_rst: WIDTH-bit, STAGES-deep clock-enabled delay line built from independent bit lanes
module jt6295_shift_rst import jt6295_pkg::*; #(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] drop
);
   genvar b;
   generate
      for (b = 0; b < WIDTH; b++) begin : g_lane
         jt6295_shift_lane #(.STAGES(STAGES)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clk_en (clk_en),
            .din    (din[b]),
            .drop   (drop[b])
         );
      end
   endgenerate
endmodule

// File: tb/tb_jt6295_shift_rst.sv
// tb_jt6295_shift_rst: directed checks of the delay line at default and corner parameters
module tb_jt6295_shift_rst;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        recirc = 1'b0;
   logic [11:0] din0_r = '0, din0, drop0;
   logic        din1 = 1'b0, drop1;
   logic [11:0] din2 = '0, drop2;
   logic [11:0] vals [4] = '{12'h0A5, 12'h15A, 12'h2C3, 12'h3D4};
   logic [7:0]  pat = 8'b1011_0010;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   assign din0 = recirc ? drop0 + 12'd1 : din0_r;

   jt6295_shift_rst #(.WIDTH(12), .STAGES(4)) u0 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .din(din0), .drop(drop0));
   jt6295_shift_rst #(.WIDTH(1), .STAGES(1)) u1 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .din(din1), .drop(drop1));
   jt6295_shift_rst #(.WIDTH(12), .STAGES(32)) u2 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .din(din2), .drop(drop2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held with all-ones input
      din0_r = 12'hFFF;
      din1 = 1'b1;
      din2 = 12'hFFF;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("rst_drop0", drop0, 0);
         chk("rst_drop1", drop1, 0);
         chk("rst_drop2", drop2, 0);
      end
      rst = 1'b0;
      din0_r = '0;
      din1 = 1'b0;
      din2 = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post_rst", drop0, 0);
      end
      // latency and order
      for (int k = 1; k <= 9; k++) begin
         din0_r = (k <= 6) ? 12'(k) : 12'd0;
         tick();
         chk("latency", drop0, (k >= 4) ? k - 3 : 0);
      end
      for (int k = 0; k < 4; k++) tick();
      // clock-enable gating, junk on disabled edges
      for (int j = 0; j < 14; j++) begin
         clk_en = ~j[0];
         din0_r = j[0] ? 12'hEEE : ((j / 2 < 4) ? vals[j/2] : 12'd0);
         tick();
         chk("gate", drop0, (j < 6) ? 12'd0 : vals[(j-6)/2]);
      end
      clk_en = 1'b1;
      // async reset between edges
      for (int k = 1; k <= 4; k++) begin
         din0_r = 12'(k);
         tick();
      end
      chk("full", drop0, 1);
      din0_r = '0;
      #2 rst = 1'b1;
      #1 chk("async_rst", drop0, 0);
      #1 rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("no_stale", drop0, 0);
      end
      // recirculation counter per slot
      rst = 1'b1;
      tick();
      rst = 1'b0;
      recirc = 1'b1;
      chk("recirc0", drop0, 0);
      for (int k = 1; k <= 16388; k++) begin
         tick();
         if (k <= 12 || k >= 16379) chk("recirc", drop0, (k / 4) & 12'hFFF);
      end
      recirc = 1'b0;
      // WIDTH=1 STAGES=1 corner, including disabled edges
      for (int k = 0; k < 8; k++) begin
         clk_en = 1'b1;
         din1 = pat[k];
         tick();
         chk("w1s1", drop1, pat[k]);
         clk_en = 1'b0;
         din1 = ~pat[k];
         tick();
         chk("w1s1_hold", drop1, pat[k]);
      end
      clk_en = 1'b1;
      // STAGES=32 corner
      for (int k = 1; k <= 40; k++) begin
         din2 = 12'h100 + 12'(k);
         tick();
         if (k >= 30) chk("s32", drop2, (k >= 32) ? 12'h100 + k - 31 : 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jt6295_shift_rst.md
Name: jt6295_shift_rst

Overview:
- Clock-enabled, multi-stage delay line (shift register) of WIDTH-bit words, cleared by an asynchronous reset.
- Used inside the ADPCM voice pipeline as recirculating storage for time-multiplexed per-channel state.
- Example uses: 12-bit sample accumulator over 4 channel slots; 1-bit channel-enable flag delayed 4 slots.
- Output is the oldest stored word, so each word re-emerges exactly STAGES enabled cycles after entry.

Parameters:
- WIDTH, 12, bit width of each stored word; legal range >= 1.
- STAGES, 4, number of pipeline stages (delay in enabled cycles); legal range >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears every stage.
- clk_en  input  1  clock enable; shift occurs only on rising clk edges where clk_en=1.
- din  input  WIDTH  word entering stage 0.
- drop  output  WIDTH  word leaving the last stage (stage STAGES-1); direct register output, no combinational path from din.

Behaviour:
- State: array stage[0..STAGES-1], each WIDTH bits.
- Reset: rst=1 forces every stage to 0 immediately, without waiting for clk. drop reads 0 while rst is high.
  - Reset dominates clk_en.
  - Deasserting rst mid-stream discards all previously stored words.
- Shift: on a rising clk edge with rst=0 and clk_en=1:
  - stage[0] <= din
  - stage[i] <= stage[i-1] for i = 1..STAGES-1
  - The word in stage[STAGES-1] is discarded.
- Hold: on a rising clk edge with clk_en=0, every stage keeps its value. drop is stable and din is ignored.
- Latency:
  - A word sampled from din at enabled edge k appears on drop immediately after enabled edge k+STAGES-1, i.e. after STAGES enabled edges total.
  - Disabled edges do not count toward the latency.
- STAGES=1: drop is a single clock-enabled register of din.
- No arithmetic or width conversion. Bits are carried unchanged and bit lanes are independent.
- No X propagation after reset: every stage is defined from the first reset onward.
- Signedness is irrelevant. The block treats data as raw bits, and the consumer applies signedness.
- Combinational feedback from drop to din (recirculation through an external adder) is legal, because drop is purely registered.

Decomposition:
- Shared package: no typedefs needed. Constants DEFAULT_WIDTH=12 and DEFAULT_STAGES=4 belong in the jt6295 package alongside the voice-count constant (4 channels).
- One natural sub-module: jt6295_shift_lane, a 1-bit, STAGES-deep clock-enabled shift chain with async reset.
  - Generated WIDTH times, one per bit lane.
  - Top level concatenates the lanes into drop.
- A flat array implementation is equally acceptable, provided behaviour is identical.

Test Plan:
1. Reset: hold rst=1 with din=12'hFFF and clk_en=1 for 10 cycles -> drop=0 throughout. Release rst, keep din=0 -> drop stays 0.
2. Latency and order (WIDTH=12, STAGES=4, clk_en=1 every cycle): feed din=1,2,3,4,5,6 on consecutive edges -> drop shows 1 after the 4th edge, then 2,3,4,5,6 on the following edges. drop reads 0 before the 4th edge.
3. Clock enable gating: clk_en toggling 1,0,1,0,… while feeding 12'h0A5,12'h15A,12'h2C3,12'h3D4 on enabled edges only -> 12'h0A5 appears after the 4th enabled edge, i.e. 7 clk edges after its entry. drop is unchanged across every disabled edge, and din values present on disabled edges never appear.
4. Asynchronous reset mid-stream: pipeline full of 1..4, assert rst between clock edges -> drop becomes 0 before the next edge. After release, previously stored words never emerge.
5. Recirculation: drive din = drop + 1 (12-bit wrap) with clk_en=1 from reset -> each of the 4 slots counts independently. drop sequence is 0,0,0,0,1,1,1,1,2,…; wraps 12'hFFF -> 0.
6. Parameter corners: WIDTH=1, STAGES=1 -> drop equals din delayed by exactly one enabled edge, and 0 during reset. WIDTH=12, STAGES=32 -> 32-enabled-edge latency with order preserved.
